// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            DivStartE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  output logic            DivBusyE,
  output logic            DivDoneE,
  output logic [XLEN-1:0] DivResultE
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   r_q, r_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand conditioning and one restoring step
  logic            is_signed;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN+1:0] r_sh, diff;
  logic [XLEN:0]   r_next;
  logic [XLEN-1:0] q_next;
  logic [XLEN-1:0] quo_fix, rem_fix;

  // Funct3E[2] only distinguishes the M-extension divide group, which the caller already decoded
  logic unused_funct3;
  assign unused_funct3 = Funct3E[2];

  assign is_signed = ~Funct3E[0];
  assign a_abs = (is_signed && ForwardedSrcAE[XLEN-1]) ? -ForwardedSrcAE : ForwardedSrcAE;
  assign b_abs = (is_signed && ForwardedSrcBE[XLEN-1]) ? -ForwardedSrcBE : ForwardedSrcBE;

  // Shift {R,Q} left one bit, then try subtracting the divisor; keep R if the trial goes negative
  assign r_sh   = {r_q, q_q[XLEN-1]};
  assign diff   = r_sh - {2'b00, b_q};
  assign r_next = diff[XLEN+1] ? r_sh[XLEN:0] : diff[XLEN:0];
  assign q_next = {q_q[XLEN-2:0], ~diff[XLEN+1]};

  // Sign fix-up applied to the final step's outputs on the way into DONE
  assign quo_fix = neg_q_q ? -q_next : q_next;
  assign rem_fix = neg_r_q ? -r_next[XLEN-1:0] : r_next[XLEN-1:0];

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    b_d      = b_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (DivStartE && !FlushE) begin
          rem_d   = Funct3E[1];
          neg_q_d = is_signed & (ForwardedSrcAE[XLEN-1] ^ ForwardedSrcBE[XLEN-1]);
          neg_r_d = is_signed & ForwardedSrcAE[XLEN-1];
          cnt_d   = '0;
          r_d     = '0;
          q_d     = a_abs;
          b_d     = b_abs;
          if (ForwardedSrcBE == '0) begin
            // Divide by zero skips iteration entirely
            state_d  = DONE;
            result_d = Funct3E[1] ? ForwardedSrcAE : '1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (FlushE) begin
          state_d = IDLE;
        end else begin
          r_d   = r_next;
          q_d   = q_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d  = DONE;
            result_d = rem_q ? rem_fix : quo_fix;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      b_q      <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      rem_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      b_q      <= b_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign DivBusyE   = (state_q == BUSY);
  assign DivDoneE   = (state_q == DONE) && !FlushE;
  assign DivResultE = result_q;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed-vector self-checking bench for div_iter
module tb_div_iter;

  logic        clk;
  logic        reset;
  logic        FlushE;
  logic        DivStartE;
  logic [2:0]  Funct3E;
  logic [31:0] SrcA, SrcB;
  logic        DivBusyE;
  logic        DivDoneE;
  logic [31:0] DivResultE;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  div_iter #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .FlushE(FlushE), .DivStartE(DivStartE), .Funct3E(Funct3E),
    .ForwardedSrcAE(SrcA), .ForwardedSrcBE(SrcB),
    .DivBusyE(DivBusyE), .DivDoneE(DivDoneE), .DivResultE(DivResultE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one op (start sampled at edge 0), observe 40 cycles, check busy count, done count/cycle, result
  task automatic run_div(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_busy, input int exp_done_cyc,
                         input bit hold_start);
    int busy, dones, done_cyc;
    logic [31:0] res;
    busy = 0; dones = 0; done_cyc = 0; res = '0;
    @(negedge clk);
    Funct3E = f; SrcA = a; SrcB = b; DivStartE = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!hold_start) DivStartE = 1'b0;
      if (DivBusyE) busy++;
      if (DivDoneE) begin
        dones++;
        if (done_cyc == 0) begin
          done_cyc = c;
          res = DivResultE;
        end
        DivStartE = 1'b0;
      end
    end
    DivStartE = 1'b0;
    check({tag, " busy_cycles"}, 32'(busy), 32'(exp_busy));
    check({tag, " done_count"}, 32'(dones), 32'd1);
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
    check({tag, " result"}, res, exp_res);
    check({tag, " result_held"}, DivResultE, exp_res);
  endtask

  initial begin
    int dones;
    reset = 1'b0; FlushE = 1'b0; DivStartE = 1'b0; Funct3E = F_DIVU; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(DivBusyE), 32'd0);
    check("reset done", 32'(DivDoneE), 32'd0);
    check("reset result", DivResultE, 32'h0);
    reset = 1'b1;

    run_div("divu_100_7",   F_DIVU, 32'd100,      32'd7,        32'h0000000E, 32, 33, 1'b0);
    run_div("div_m7_2",     F_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32, 33, 1'b0);
    run_div("rem_m7_2",     F_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32, 33, 1'b0);
    run_div("divu_5_0",     F_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 0,  1,  1'b0);
    run_div("rem_5_0",      F_REM,  32'd5,        32'd0,        32'h00000005, 0,  1,  1'b0);
    run_div("div_ovf",      F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32, 33, 1'b0);
    run_div("rem_ovf",      F_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32, 33, 1'b0);
    run_div("remu_big_2",   F_REMU, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32, 33, 1'b0);
    run_div("div_neg_neg",  F_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 32, 33, 1'b0);
    run_div("rem_pos_neg",  F_REM,  32'd100,      32'hFFFFFFF9, 32'h00000002, 32, 33, 1'b0);
    run_div("divu_hold",    F_DIVU, 32'd100,      32'd7,        32'h0000000E, 32, 33, 1'b1);

    // Start together with flush in IDLE: start dropped
    @(negedge clk);
    Funct3E = F_DIVU; SrcA = 32'd50; SrcB = 32'd5; DivStartE = 1'b1; FlushE = 1'b1;
    @(negedge clk);
    DivStartE = 1'b0; FlushE = 1'b0;
    check("flush_idle busy", 32'(DivBusyE), 32'd0);
    check("flush_idle done", 32'(DivDoneE), 32'd0);
    check("flush_idle result", DivResultE, 32'h0000000E);

    // Flush during BUSY at cycle 10
    dones = 0;
    Funct3E = F_DIVU; SrcA = 32'd100; SrcB = 32'd7; DivStartE = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      DivStartE = 1'b0;
      if (DivDoneE) dones++;
      if (c == 9) SrcA = 32'd1;
      if (c == 10) begin
        check("flush_busy busy_before", 32'(DivBusyE), 32'd1);
        FlushE = 1'b1;
      end
      if (c == 11) begin
        FlushE = 1'b0;
        check("flush_busy busy_after", 32'(DivBusyE), 32'd0);
        check("flush_busy result", DivResultE, 32'h0000000E);
      end
    end
    repeat (30) begin
      @(negedge clk);
      if (DivDoneE) dones++;
    end
    check("flush_busy no_done", 32'(dones), 32'd0);
    run_div("divu_9_3", F_DIVU, 32'd9, 32'd3, 32'h00000003, 32, 33, 1'b0);

    // Async reset mid-op at cycle 5
    @(negedge clk);
    Funct3E = F_DIVU; SrcA = 32'd100; SrcB = 32'd7; DivStartE = 1'b1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      DivStartE = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("midreset busy", 32'(DivBusyE), 32'd0);
    check("midreset done", 32'(DivDoneE), 32'd0);
    check("midreset result", DivResultE, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    run_div("post_reset", F_DIVU, 32'd100, 32'd7, 32'h0000000E, 32, 33, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
